// File: rtl/wdata_fifo_mc.sv
// rtl/wdata_fifo_mc.sv - multi-channel first-word-fall-through write-data FIFO
// One independent queue per bank/channel with occupancy, almost-full and sticky error flags.
module wdata_fifo_mc #(
    parameter int  DATA_WIDTH  = 128,
    parameter int  DEPTH       = 32,
    parameter int  NUM_CH      = 4,
    parameter int  AFULL_SPACE = 2,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wen,
    input  logic [CH_W-1:0]          wr_ch,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     ren,
    input  logic [CH_W-1:0]          rd_ch,
    input  logic                     clr_err,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH-1:0]        virtual_full,
    output logic [NUM_CH-1:0]        empty,
    output logic [NUM_CH*(AW+1)-1:0] count,
    output logic                     overflow,
    output logic                     underflow
);

    logic [NUM_CH-1:0]                 wr_acc;
    logic [NUM_CH-1:0]                 rd_acc;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] head;
    logic                              ovf_ev;
    logic                              unf_ev;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [AW:0]           wr_ptr;
        logic [AW:0]           rd_ptr;
        logic [AW:0]           cnt;
        logic [AW+1:0]         space;
        logic [DATA_WIDTH-1:0] mem [DEPTH];

        // Flags depend only on the registered pointers, never on same-cycle requests.
        assign cnt             = wr_ptr - rd_ptr;
        assign space           = (AW+2)'(DEPTH) - {1'b0, cnt};
        assign empty[c]        = (wr_ptr == rd_ptr);
        assign full[c]         = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
        assign virtual_full[c] = (space < (AW+2)'(AFULL_SPACE));
        assign count[c*(AW+1) +: AW+1] = cnt;
        assign head[c]         = mem[rd_ptr[AW-1:0]];

        // An out-of-range channel index matches no queue, so it is never accepted.
        assign wr_acc[c] = wen && (wr_ch == CH_W'(c)) && !full[c];
        assign rd_acc[c] = ren && (rd_ch == CH_W'(c)) && !empty[c];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc[c]) wr_ptr <= wr_ptr + 1'b1;
                if (rd_acc[c]) rd_ptr <= rd_ptr + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (wr_acc[c]) mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    always_comb begin
        data_out = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch == CH_W'(c) && !empty[c]) data_out = head[c];
        end
    end

    assign ovf_ev = wen && !(|wr_acc);
    assign unf_ev = ren && !(|rd_acc);

    // A new error in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_ev | (overflow & ~clr_err);
            underflow <= unf_ev | (underflow & ~clr_err);
        end
    end

endmodule

// File: doc/wdata_fifo_mc.md
# wdata_fifo_mc

Parametrised multi-channel write-data FIFO for the command scheduler. It holds one independent first-word-fall-through queue per DRAM bank or channel, so write data can be buffered per bank and drained in the order the scheduler issues write commands. Each queue has occupancy and true-full tracking, a programmable almost-full margin, and sticky overflow/underflow error flags. Width, depth and channel count are all parameters.

## Interface
- DATA_WIDTH, 128: width of one write-data entry.
- DEPTH, 32: entries per channel; power of two, ≥2.
- NUM_CH, 4: number of independent queues; ≥1.
- AFULL_SPACE, 2: virtual_full[c] is high when free entries of channel c < AFULL_SPACE; range 1..DEPTH.
- CH_W, derived: max(1, clog2(NUM_CH)).
- AW, derived: clog2(DEPTH).
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- wen  in  1  write request.
- wr_ch  in  CH_W  target channel of the write.
- data_in  in  DATA_WIDTH  write data.
- ren  in  1  read (pop) request.
- rd_ch  in  CH_W  channel to read or pop.
- clr_err  in  1  synchronous clear of overflow and underflow.
- data_out  out  DATA_WIDTH  head entry of rd_ch; forced to 0 when that channel is empty.
- full  out  NUM_CH  per channel: count == DEPTH.
- virtual_full  out  NUM_CH  per channel: DEPTH − count < AFULL_SPACE.
- empty  out  NUM_CH  per channel: count == 0.
- count  out  NUM_CH*(AW+1)  per-channel occupancy, flattened; channel c is at bits [c*(AW+1) +: AW+1].
- overflow  out  1  sticky: a write to a full channel was dropped.
- underflow  out  1  sticky: a pop from an empty channel was ignored.

## Operation
- **Per-channel state:** write pointer and read pointer, each AW+1 bits with a wrap bit.
  - count = wr_ptr − rd_ptr, modulo 2^(AW+1).
  - full means the pointers are equal except for the MSB. empty means the pointers are fully equal.
  - All DEPTH entries are usable; no entry is reserved.
- **Storage:** NUM_CH × DEPTH × DATA_WIDTH. Entry index = ptr[AW-1:0]. Storage is not reset.
- **Write:** accepted when wen=1 and full[wr_ch]=0.
  - data_in is stored at wr_ptr[wr_ch], and wr_ptr[wr_ch] increments (wrapping naturally).
  - A write to a full channel is dropped, even if the same channel is popped in the same cycle. The dropped write sets overflow.
- **Read:** accepted when ren=1 and empty[rd_ch]=0. rd_ptr[rd_ch] increments.
  - A pop of an empty channel is ignored, even if the same channel is written in the same cycle (no bypass). The ignored pop sets underflow.
- **Simultaneous write and read to the same non-full, non-empty channel:** both are accepted and count is unchanged.
- **Different channels:** a write and a read to different channels in the same cycle are fully independent.
- **Out-of-range channel index** (wr_ch or rd_ch ≥ NUM_CH): the write or pop is ignored, the matching error flag is set, and data_out = 0.
- **data_out:** combinational from rd_ch and the registered rd_ptr. Equals storage[rd_ch][rd_ptr[AW-1:0]] when not empty, otherwise 0.
- **Flags** (full, virtual_full, empty, count) are combinational from the registered pointers only. They never depend on same-cycle wen or ren.
- **Error flags:**
  - clr_err=1 clears overflow and underflow.
  - A new error event in the same cycle as clr_err takes priority, so the flag stays 1.

## Timing
- **Reset** (rst_n low, asynchronous): all pointers = 0, overflow = underflow = 0.
  - Resulting outputs: empty = all 1s, full = 0, virtual_full = 0 (provided AFULL_SPACE ≤ DEPTH), count = 0, data_out = 0.
  - Reset asserted mid-operation discards all queued data immediately. Deassertion is synchronised externally.
- **Write-to-visibility latency:** 1 cycle. A write at edge N drives empty[c]=0, count+1, and (if the channel was empty) the new data on data_out in the cycle after edge N.
- **Pop:** data_out advances to the next entry right after the popping edge. There are no bubbles, so back-to-back pops deliver one entry per cycle.
- **Throughput:** one write plus one pop per cycle.
- **Flag timing:** full and virtual_full rise in the cycle after the write that crosses the threshold, and fall in the cycle after the pop that crosses back.

## Test plan
- **Reset state:** assert rst_n=0 asynchronously mid-cycle. All outputs must take their reset values without waiting for a clock edge: empty=4'b1111, count=0, data_out=0.
- **Fill and wrap, DEPTH=32, channel 2:**
  - Write 32 entries 0x100..0x11F. Then full[2]=1, virtual_full[2] must have risen after the 31st write, and count=32.
  - A 33rd write is dropped and sets overflow=1.
  - Pop all 32: data_out must read 0x100..0x11F in order, then empty[2]=1.
  - Repeat the fill/drain 3 times to exercise pointer wrap.
- **Independence:** interleave writes to channels 0 and 3 with pops from channel 1.
  - Each queue must preserve its own order.
  - counts must match a reference model every cycle.
  - Channel 1, which was never written, underflows on pop: underflow=1 and data_out=0.
- **Simultaneous events on channel 1 holding 5 entries:** apply wen and ren in the same cycle for 10 cycles. count must stay at 5 and data order must be preserved.
  - Then, on the empty channel, a write and pop in the same cycle: the pop is ignored, underflow=1, and count becomes 1.
  - Then, on the full channel, a write and pop in the same cycle: the write is dropped, overflow=1, and count becomes 31.
- **Error clearing:** assert clr_err alone; both flags must clear to 0.
  - Assert clr_err in the same cycle as an overflowing write; overflow must remain 1.
- **Parameter sweep:** run the above with (DATA_WIDTH, DEPTH, NUM_CH, AFULL_SPACE) = (8,2,1,1), (64,4,3,2) and (128,32,4,2).
  - The out-of-range channel index 3 with NUM_CH=3 must be ignored and flagged.
